// File: rtl/multi_cycle_fsm_ctrl.sv
// multi_cycle_fsm_ctrl: main control FSM for a multi-cycle MIPS-I style datapath.
// Produces the per-state datapath strobes and selects, and counts retired
// instructions.
//
// state      | meaning
// -----------+---------------------------------------------------------
// RESET      | idle after reset, every strobe low
// FETCH      | read IR from memory, PC+4; held while memory is busy
// DECODE     | register read, branch target precompute, dispatch
// MEM_ADDR   | effective address = A + sign-ext imm
// MEM_READ   | load data read; held while memory is busy
// MEM_WB     | write MDR into rt
// MEM_WRITE  | store data write; held while memory is busy
// R_EXEC     | ALU op selected by funct on A,B
// R_WB       | write ALUOut into rd
// BEQ / BNE  | compare A,B and conditionally load branch target
// JUMP       | PC <- jump target
// I_EXEC     | ALU op selected by opcode on A, sign-ext imm
// I_WB       | write ALUOut into rt
// JAL        | PC <- jump target, r31 <- PC
// JR         | PC <- A
// JALR       | PC <- A, rd <- PC
// LUI        | ALU computes imm << 16
// SHIFT_EXEC | shift B by shamt
// TRAP       | undecodable instruction; only reset leaves this state
module multi_cycle_fsm_ctrl #(
    parameter int CNT_W     = 32,
    parameter bit HAS_SHIFT = 1'b1,
    parameter bit HAS_LINK  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             memReady,
    output logic [1:0]       pcWriteCond,
    output logic             pcWrite,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic [1:0]       pcSource,
    output logic [2:0]       aluOp,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       memToReg,
    output logic [1:0]       regDst,
    output logic             illegal,
    output logic [CNT_W-1:0] retireCount,
    output logic [4:0]       state
);

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_DECODE     = 5'd2,
        S_MEM_ADDR   = 5'd3,
        S_MEM_READ   = 5'd4,
        S_MEM_WB     = 5'd5,
        S_MEM_WRITE  = 5'd6,
        S_R_EXEC     = 5'd7,
        S_R_WB       = 5'd8,
        S_BEQ        = 5'd9,
        S_BNE        = 5'd10,
        S_JUMP       = 5'd11,
        S_I_EXEC     = 5'd12,
        S_I_WB       = 5'd13,
        S_JAL        = 5'd14,
        S_JR         = 5'd15,
        S_JALR       = 5'd16,
        S_LUI        = 5'd17,
        S_SHIFT_EXEC = 5'd18,
        S_TRAP       = 5'd19
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    state_t           state_q;
    state_t           state_d;
    state_t           decode_next;
    logic             retire_en;
    logic [CNT_W-1:0] retire_q;

    // Dispatch target for the instruction currently held in IR.
    always_comb begin
        decode_next = S_TRAP;
        case (opcode)
            OP_R: begin
                if (funct == FN_JR) begin
                    decode_next = HAS_LINK ? S_JR : S_TRAP;
                end else if (funct == FN_JALR) begin
                    decode_next = HAS_LINK ? S_JALR : S_TRAP;
                end else if ((funct == FN_SLL) || (funct == FN_SRL)) begin
                    decode_next = HAS_SHIFT ? S_SHIFT_EXEC : S_TRAP;
                end else begin
                    decode_next = S_R_EXEC;
                end
            end
            OP_J:    decode_next = S_JUMP;
            OP_JAL:  decode_next = HAS_LINK ? S_JAL : S_TRAP;
            OP_BEQ:  decode_next = S_BEQ;
            OP_BNE:  decode_next = S_BNE;
            OP_ADDI,
            OP_SLTI,
            OP_ANDI,
            OP_ORI,
            OP_XORI: decode_next = S_I_EXEC;
            OP_LUI:  decode_next = S_LUI;
            OP_LW,
            OP_SW:   decode_next = S_MEM_ADDR;
            default: decode_next = S_TRAP;
        endcase
    end

    // Next-state selection; memory-wait states hold until memReady.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE:     state_d = decode_next;
            // IR is stable for the whole instruction, so the opcode can be
            // re-examined here instead of carrying a load/store flag.
            S_MEM_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:   state_d = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:     state_d = S_FETCH;
            S_MEM_WRITE:  state_d = memReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:     state_d = S_R_WB;
            S_SHIFT_EXEC: state_d = S_R_WB;
            S_R_WB:       state_d = S_FETCH;
            S_BEQ:        state_d = S_FETCH;
            S_BNE:        state_d = S_FETCH;
            S_JUMP:       state_d = S_FETCH;
            S_JAL:        state_d = S_FETCH;
            S_JR:         state_d = S_FETCH;
            S_JALR:       state_d = S_FETCH;
            S_I_EXEC:     state_d = S_I_WB;
            S_LUI:        state_d = S_I_WB;
            S_I_WB:       state_d = S_FETCH;
            S_TRAP:       state_d = S_TRAP;
            default:      state_d = S_RESET;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath controls, a pure function of state (plus memReady in FETCH).
    always_comb begin
        pcWriteCond = 2'b00;
        pcWrite     = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        pcSource    = 2'b00;
        aluOp       = 3'b000;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        memToReg    = 2'b00;
        regDst      = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                // IR and PC capture only on the cycle the read completes.
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
            end
            S_MEM_ADDR: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 2'b01;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_R_EXEC: begin
                aluSrcA = 2'b01;
                aluOp   = 3'b010;
            end
            S_SHIFT_EXEC: begin
                aluSrcA = 2'b10;
                aluOp   = 3'b010;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 2'b01;
            end
            S_BEQ, S_BNE: begin
                aluSrcA     = 2'b01;
                aluOp       = 3'b001;
                pcSource    = 2'b01;
                pcWriteCond = (state_q == S_BEQ) ? 2'b01 : 2'b10;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_JAL: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
                regWrite = 1'b1;
                regDst   = 2'b10;
                memToReg = 2'b10;
            end
            S_JR: begin
                pcWrite  = 1'b1;
                pcSource = 2'b11;
            end
            S_JALR: begin
                pcWrite  = 1'b1;
                pcSource = 2'b11;
                regWrite = 1'b1;
                regDst   = 2'b01;
                memToReg = 2'b10;
            end
            S_I_EXEC: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                aluOp   = 3'b011;
            end
            S_LUI: begin
                aluSrcB = 2'b10;
                aluOp   = 3'b100;
            end
            S_I_WB: begin
                regWrite = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    // An instruction retires when control returns to FETCH from its last
    // state; the RESET->FETCH step and FETCH stalls do not count.
    assign retire_en = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                       (state_q != S_RESET);

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (retire_en) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retireCount = retire_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multi_cycle_fsm_ctrl.sv
// Bench for multi_cycle_fsm_ctrl: three parameterisations driven one at a time
// (the others parked in reset), every cycle compared to an instruction-path
// reference model.
module tb_multi_cycle_fsm_ctrl;

    localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                   S_MEM_READ = 4, S_MEM_WB = 5, S_MEM_WRITE = 6, S_R_EXEC = 7,
                   S_R_WB = 8, S_BEQ = 9, S_BNE = 10, S_JUMP = 11, S_I_EXEC = 12,
                   S_I_WB = 13, S_JAL = 14, S_JR = 15, S_JALR = 16, S_LUI = 17,
                   S_SHIFT_EXEC = 18, S_TRAP = 19;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_XORI = 6'b001110, OP_LUI = 6'b001111, OP_LW = 6'b100011,
                           OP_SW = 6'b101011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_JR = 6'b001000,
                           FN_JALR = 6'b001001, FN_SLL = 6'b000000, FN_SRL = 6'b000010;

    logic        clk;
    logic        rst_v      [3];
    logic [5:0]  opcode_v   [3];
    logic [5:0]  funct_v    [3];
    logic        mr_v       [3];
    logic [1:0]  pwc_v      [3];
    logic        pw_v       [3];
    logic        iord_v     [3];
    logic        mrd_v      [3];
    logic        mwr_v      [3];
    logic        irw_v      [3];
    logic        rw_v       [3];
    logic [1:0]  psrc_v     [3];
    logic [2:0]  aop_v      [3];
    logic [1:0]  sa_v       [3];
    logic [1:0]  sb_v       [3];
    logic [1:0]  m2r_v      [3];
    logic [1:0]  rd_v       [3];
    logic        ill_v      [3];
    logic [4:0]  state_v    [3];
    logic [21:0] ctl_v      [3];
    logic [31:0] cnt_v      [3];
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int          total, bad;
    int          m_state;
    logic [31:0] m_count;
    logic [31:0] m_mask;
    bit          hs, hl;
    int          m_path[$];

    multi_cycle_fsm_ctrl u_dflt (
        .clk(clk), .rst(rst_v[0]), .opcode(opcode_v[0]), .funct(funct_v[0]),
        .memReady(mr_v[0]), .pcWriteCond(pwc_v[0]), .pcWrite(pw_v[0]), .iorD(iord_v[0]),
        .memRead(mrd_v[0]), .memWrite(mwr_v[0]), .irWrite(irw_v[0]), .regWrite(rw_v[0]),
        .pcSource(psrc_v[0]), .aluOp(aop_v[0]), .aluSrcA(sa_v[0]), .aluSrcB(sb_v[0]),
        .memToReg(m2r_v[0]), .regDst(rd_v[0]), .illegal(ill_v[0]),
        .retireCount(cnt_a), .state(state_v[0]));

    multi_cycle_fsm_ctrl #(.CNT_W(32), .HAS_SHIFT(1'b0), .HAS_LINK(1'b0)) u_min (
        .clk(clk), .rst(rst_v[1]), .opcode(opcode_v[1]), .funct(funct_v[1]),
        .memReady(mr_v[1]), .pcWriteCond(pwc_v[1]), .pcWrite(pw_v[1]), .iorD(iord_v[1]),
        .memRead(mrd_v[1]), .memWrite(mwr_v[1]), .irWrite(irw_v[1]), .regWrite(rw_v[1]),
        .pcSource(psrc_v[1]), .aluOp(aop_v[1]), .aluSrcA(sa_v[1]), .aluSrcB(sb_v[1]),
        .memToReg(m2r_v[1]), .regDst(rd_v[1]), .illegal(ill_v[1]),
        .retireCount(cnt_b), .state(state_v[1]));

    multi_cycle_fsm_ctrl #(.CNT_W(4)) u_narrow (
        .clk(clk), .rst(rst_v[2]), .opcode(opcode_v[2]), .funct(funct_v[2]),
        .memReady(mr_v[2]), .pcWriteCond(pwc_v[2]), .pcWrite(pw_v[2]), .iorD(iord_v[2]),
        .memRead(mrd_v[2]), .memWrite(mwr_v[2]), .irWrite(irw_v[2]), .regWrite(rw_v[2]),
        .pcSource(psrc_v[2]), .aluOp(aop_v[2]), .aluSrcA(sa_v[2]), .aluSrcB(sb_v[2]),
        .memToReg(m2r_v[2]), .regDst(rd_v[2]), .illegal(ill_v[2]),
        .retireCount(cnt_c), .state(state_v[2]));

    assign cnt_v[0] = cnt_a;
    assign cnt_v[1] = cnt_b;
    assign cnt_v[2] = {28'd0, cnt_c};

    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign ctl_v[g] = {pwc_v[g], pw_v[g], iord_v[g], mrd_v[g], mwr_v[g], irw_v[g],
                           rw_v[g], psrc_v[g], aop_v[g], sa_v[g], sb_v[g], m2r_v[g],
                           rd_v[g], ill_v[g]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control word the specification lists for each state.
    function automatic logic [21:0] exp_ctl(input int s, input logic mr);
        logic [1:0] pwc, psrc, sa, sb, m2r, rd;
        logic       pw, iord, mrd, mwr, irw, rw, ill;
        logic [2:0] aop;
        pwc = 0; psrc = 0; sa = 0; sb = 0; m2r = 0; rd = 0;
        pw = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; ill = 0; aop = 0;
        case (s)
            S_FETCH:      begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:     sb = 2'b11;
            S_MEM_ADDR:   begin sa = 2'b01; sb = 2'b10; end
            S_MEM_READ:   begin mrd = 1; iord = 1; end
            S_MEM_WB:     begin rw = 1; m2r = 2'b01; end
            S_MEM_WRITE:  begin mwr = 1; iord = 1; end
            S_R_EXEC:     begin sa = 2'b01; aop = 3'b010; end
            S_SHIFT_EXEC: begin sa = 2'b10; aop = 3'b010; end
            S_R_WB:       begin rw = 1; rd = 2'b01; end
            S_BEQ:        begin sa = 2'b01; aop = 3'b001; psrc = 2'b01; pwc = 2'b01; end
            S_BNE:        begin sa = 2'b01; aop = 3'b001; psrc = 2'b01; pwc = 2'b10; end
            S_JUMP:       begin pw = 1; psrc = 2'b10; end
            S_JAL:        begin pw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            S_JR:         begin pw = 1; psrc = 2'b11; end
            S_JALR:       begin pw = 1; psrc = 2'b11; rw = 1; rd = 2'b01; m2r = 2'b10; end
            S_I_EXEC:     begin sa = 2'b01; sb = 2'b10; aop = 3'b011; end
            S_LUI:        begin sb = 2'b10; aop = 3'b100; end
            S_I_WB:       rw = 1;
            S_TRAP:       ill = 1;
            default:      ill = 0;
        endcase
        return {pwc, pw, iord, mrd, mwr, irw, rw, psrc, aop, sa, sb, m2r, rd, ill};
    endfunction

    // Sequence of states an instruction walks through after FETCH.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        m_path.delete();
        m_path.push_back(S_DECODE);
        case (op)
            OP_R: begin
                if (fn == FN_JR)                       m_path.push_back(hl ? S_JR : S_TRAP);
                else if (fn == FN_JALR)                m_path.push_back(hl ? S_JALR : S_TRAP);
                else if (fn == FN_SLL || fn == FN_SRL) begin
                    if (hs) begin m_path.push_back(S_SHIFT_EXEC); m_path.push_back(S_R_WB); end
                    else m_path.push_back(S_TRAP);
                end else begin
                    m_path.push_back(S_R_EXEC); m_path.push_back(S_R_WB);
                end
            end
            OP_J:   m_path.push_back(S_JUMP);
            OP_JAL: m_path.push_back(hl ? S_JAL : S_TRAP);
            OP_BEQ: m_path.push_back(S_BEQ);
            OP_BNE: m_path.push_back(S_BNE);
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                m_path.push_back(S_I_EXEC); m_path.push_back(S_I_WB);
            end
            OP_LUI: begin m_path.push_back(S_LUI); m_path.push_back(S_I_WB); end
            OP_LW: begin
                m_path.push_back(S_MEM_ADDR); m_path.push_back(S_MEM_READ);
                m_path.push_back(S_MEM_WB);
            end
            OP_SW: begin m_path.push_back(S_MEM_ADDR); m_path.push_back(S_MEM_WRITE); end
            default: m_path.push_back(S_TRAP);
        endcase
    endtask

    // Advance the model over one rising edge with the given inputs.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic mr);
        if (m_state == S_TRAP) begin
            m_state = S_TRAP;
        end else if (m_state == S_RESET) begin
            m_state = S_FETCH;
        end else if ((m_state == S_FETCH || m_state == S_MEM_READ ||
                      m_state == S_MEM_WRITE) && !mr) begin
            m_state = m_state;
        end else if (m_state == S_FETCH) begin
            plan(op, fn);
            m_state = m_path.pop_front();
        end else if (m_path.size() > 0) begin
            m_state = m_path.pop_front();
        end else begin
            m_state = S_FETCH;
            m_count = (m_count + 32'd1) & m_mask;
        end
    endtask

    // One clock: drive inputs after the falling edge, compare, advance model.
    task automatic cyc(input int i, input logic [5:0] op, input logic [5:0] fn,
                       input logic mr);
        @(negedge clk);
        opcode_v[i] = op;
        funct_v[i]  = fn;
        mr_v[i]     = mr;
        #1;
        chk("state", 32'(state_v[i]), 32'(m_state));
        chk("ctl", 32'(ctl_v[i]), 32'(exp_ctl(m_state, mr)));
        chk("count", cnt_v[i], m_count);
        step(op, fn, mr);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset mid-cycle; its effect must be visible before any clock edge.
    task automatic do_reset(input int i);
        @(negedge clk);
        #1;
        rst_v[i] = 1'b0;
        #1;
        chk("rst_state", 32'(state_v[i]), 32'd0);
        chk("rst_ctl", 32'(ctl_v[i]), 32'd0);
        chk("rst_count", cnt_v[i], 32'd0);
        #2;
        rst_v[i] = 1'b1;
        m_state = S_RESET;
        m_count = 32'd0;
        m_path.delete();
        // the upcoming edge is the RESET->FETCH step
        step(6'd0, 6'd0, 1'b1);
    endtask

    function automatic logic rnd_mr();
        return $urandom_range(0, 3) != 0;
    endfunction

    // Run one instruction from FETCH until it retires or traps.
    task automatic run_instr(input int i, input logic [5:0] op, input logic [5:0] fn);
        int guard;
        bit left;
        guard = 0;
        left  = 0;
        while (guard <= 200) begin
            cyc(i, op, fn, rnd_mr());
            guard++;
            if (m_state != S_FETCH) left = 1;
            if ((left && m_state == S_FETCH) || m_state == S_TRAP) break;
        end
        chk("instr_budget", 32'(guard > 200), 32'd0);
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        int sel;
        sel = $urandom_range(0, 21);
        fn  = 6'($urandom_range(0, 63));
        op  = OP_R;
        case (sel)
            0:  fn = FN_ADD;
            1:  fn = FN_SUB;
            2:  fn = FN_JR;
            3:  fn = FN_JALR;
            4:  fn = FN_SLL;
            5:  fn = FN_SRL;
            6:  op = OP_J;
            7:  op = OP_JAL;
            8:  op = OP_BEQ;
            9:  op = OP_BNE;
            10: op = OP_ADDI;
            11: op = OP_SLTI;
            12: op = OP_ANDI;
            13: op = OP_ORI;
            14: op = OP_XORI;
            15: op = OP_LUI;
            16, 17: op = OP_LW;
            18, 19: op = OP_SW;
            default: op = 6'($urandom_range(0, 63));
        endcase
    endtask

    task automatic rand_run(input int i, input int n);
        logic [5:0] op, fn;
        for (int k = 0; k < n; k++) begin
            pick(op, fn);
            run_instr(i, op, fn);
            if (m_state == S_TRAP) begin
                repeat (2) cyc(i, op, fn, rnd_mr());
                do_reset(i);
            end
        end
    endtask

    initial begin
        int rd_cycles;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; opcode_v[i] = 6'd0; funct_v[i] = 6'd0; mr_v[i] = 1'b0;
        end
        m_state = S_RESET; m_count = 0; m_mask = 32'hFFFF_FFFF; hs = 1; hl = 1;
        repeat (2) @(negedge clk);

        // ---- default parameters ----
        do_reset(0);
        repeat (4) cyc(0, OP_R, FN_ADD, 1'b1);
        settle();
        chk("add_state", 32'(state_v[0]), 32'd1);
        chk("add_retire", cnt_v[0], 32'd1);

        rd_cycles = 0;
        repeat (3) cyc(0, OP_LW, 6'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, OP_LW, 6'd0, k == 3);
            if (mrd_v[0] === 1'b1 && iord_v[0] === 1'b1) rd_cycles++;
        end
        chk("lw_stall_cycles", 32'(rd_cycles), 32'd4);
        cyc(0, OP_LW, 6'd0, 1'b1);
        chk("lw_wb_state", 32'(state_v[0]), 32'd5);
        chk("lw_wb_regwrite", 32'(rw_v[0]), 32'd1);
        chk("lw_wb_memtoreg", 32'(m2r_v[0]), 32'd1);

        repeat (3) cyc(0, OP_JAL, 6'd0, 1'b1);
        chk("jal_state", 32'(state_v[0]), 32'd14);
        chk("jal_ctl", {pw_v[0], psrc_v[0], rd_v[0], m2r_v[0], rw_v[0]},
            32'b1_10_10_10_1);

        repeat (3) cyc(0, OP_R, FN_SRL, 1'b1);
        chk("srl_state", 32'(state_v[0]), 32'd18);
        chk("srl_srca", 32'(sa_v[0]), 32'd2);
        cyc(0, OP_R, FN_SRL, 1'b1);

        rand_run(0, 250);

        repeat (3) cyc(0, OP_LW, 6'd0, 1'b1);
        repeat (2) cyc(0, OP_LW, 6'd0, 1'b0);
        do_reset(0);

        repeat (2) cyc(0, 6'b111111, 6'd0, 1'b1);
        repeat (4) cyc(0, 6'b111111, 6'd0, rnd_mr());
        chk("trap_illegal", 32'(ill_v[0]), 32'd1);
        do_reset(0);
        rst_v[0] = 1'b0;

        // ---- no shift, no link ----
        hs = 0; hl = 0;
        do_reset(1);
        repeat (3) cyc(1, OP_R, FN_SLL, 1'b1);
        chk("sll_trap", 32'(state_v[1]), 32'd19);
        do_reset(1);
        repeat (3) cyc(1, OP_R, FN_JALR, 1'b1);
        chk("jalr_trap", 32'(state_v[1]), 32'd19);
        do_reset(1);
        rand_run(1, 120);
        rst_v[1] = 1'b0;

        // ---- 4-bit retire counter ----
        hs = 1; hl = 1; m_mask = 32'h0000_000F;
        do_reset(2);
        for (int k = 1; k <= 16; k++) begin
            run_instr(2, OP_ADDI, 6'($urandom_range(0, 63)));
            settle();
            if (k == 15) chk("cnt_15", cnt_v[2], 32'd15);
            if (k == 16) chk("cnt_wrap", cnt_v[2], 32'd0);
        end
        repeat (3) cyc(2, OP_R, FN_ADD, 1'b0);
        do_reset(2);
        rand_run(2, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
